// File: rtl/rr_decode_arbiter_pkg.sv
// ============================================================================
// Module      : rr_decode_arbiter_pkg
// Description : Shared constants, state encoding and round-robin search helper
//               for the rr_decode_arbiter block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_decode_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    localparam int STATE_W = 1;
    typedef logic [STATE_W-1:0] state_t;
    localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;
    localparam logic [STATE_W-1:0] ST_GRANT = 1'b1;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Walks offsets from the far end down so the offset closest to ptr is
    // the last writer and therefore the winner.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_decode_arbiter_if.sv
// ============================================================================
// Module      : rr_decode_arbiter_if
// Description : Request/grant bundle between requesters (master) and the
//               round-robin arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_decode_arbiter_if;
    import rr_decode_arbiter_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );

endinterface

`default_nettype wire

// File: rtl/rr_decode_arbiter_grant_dec_2x4.sv
// ============================================================================
// Module      : grant_dec_2x4
// Description : 2-to-4 one-hot decode with enable, fed from registered index
//               and valid so the grant lines stay glitch-free.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grant_dec_2x4
    import rr_decode_arbiter_pkg::*;
(
    input  wire logic [IDX_W-1:0]   i_idx,
    input  wire logic               i_en,
    output logic      [NUM_REQ-1:0] o_onehot
);

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_dec
            assign o_onehot[g] = i_en && (i_idx == IDX_W'(g));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/rr_decode_arbiter.sv
// ============================================================================
// Module      : rr_decode_arbiter
// Description : Four-way round-robin arbiter with hold limit and a guaranteed
//               dead cycle between tenures; grant is decoded from a 2-bit index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rr_decode_arbiter_if.slave bus
);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic               r_valid;
    logic [CNT_W-1:0]   r_hold_cnt;

    pick_t              w_pick;
    logic               w_arb_go;
    logic               w_timeout;
    logic               w_release;

    assign w_pick    = rr_pick(bus.req, r_ptr);
    assign w_arb_go  = bus.en && w_pick.found;
    assign w_release = !bus.req[r_idx] || w_timeout;

    generate
        if (MAX_HOLD == 0) begin : g_no_timeout
            assign w_timeout = 1'b0;
        end else begin : g_timeout
            assign w_timeout = (r_hold_cnt >= CNT_W'(MAX_HOLD));
        end
    endgenerate

    // Arbitration only ever happens from IDLE, so a release edge can never
    // also be a grant edge: that is what enforces the dead cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_go) begin
                        r_state    <= ST_GRANT;
                        r_idx      <= w_pick.idx;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= CNT_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state    <= ST_IDLE;
                        r_valid    <= 1'b0;
                        r_ptr      <= r_idx + IDX_W'(1);
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    grant_dec_2x4 u_grant_dec (
        .i_idx    (r_idx),
        .i_en     (r_valid),
        .o_onehot (bus.gnt)
    );

    assign bus.gnt_idx   = r_idx;
    assign bus.gnt_valid = r_valid;

endmodule

`default_nettype wire

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one decoded 2-to-4 select resource between four requesters.
- Picks one requester, encodes it as a 2-bit index and drives a one-hot 4-bit grant through a 2-to-4 decode.
- Holds the grant until release or hold-limit timeout, then always inserts one dead cycle before the next grant.
- Sits in front of any 4-way shared datapath whose select lines the team drives from a 2x4 decoder.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles per tenure; 0 = unlimited.
- CNT_W, 8: width of the hold counter; MAX_HOLD must be < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; gates new grants only.
- req  input  4  request lines, bit i = requester i.
- gnt  output  4  one-hot grant, decoded from gnt_idx; 0000 when no grant.
- gnt_idx  output  2  index of current/last granted requester.
- gnt_valid  output  1  high while gnt is non-zero.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, ptr=00, hold_cnt=0. All outputs are registered and clear immediately on rst_n fall.
- States: IDLE, GRANT.
- Arbitration runs only in IDLE:
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first i with req[i]=1 wins.
  - Arbitration requires en=1 and req!=0000.
- IDLE -> GRANT at the edge where arbitration succeeds:
  - gnt_idx<=winner, gnt<=decode(winner), gnt_valid<=1, hold_cnt<=1.
  - Latency: req sampled at edge N, grant visible after edge N (1 cycle).
- GRANT stays GRANT while req[gnt_idx]=1 AND (MAX_HOLD==0 OR hold_cnt<MAX_HOLD). hold_cnt increments each edge and saturates at all-ones.
- GRANT -> IDLE at the edge where req[gnt_idx]=0 or hold_cnt==MAX_HOLD (MAX_HOLD!=0):
  - gnt<=0000, gnt_valid<=0, ptr<=gnt_idx+1 (mod 4, wraps 3->0).
  - gnt_idx keeps the last value.
- The dead cycle is guaranteed: no arbitration happens on the same edge as a release, so gnt is 0000 for at least one cycle between tenures.
- en=0:
  - In IDLE: no new grant.
  - In GRANT: no effect; the current tenure runs to completion.
- Requests of other requesters during GRANT are ignored; they are not latched.
- A requester dropping req for exactly the grant edge is not a fault; the tenure ends at the next edge.
- Simultaneous release and timeout both cause the same transition.
- gnt is always one-hot or zero; gnt_valid == |gnt at all times.

Decomposition:
- Shared package holds:
  - NUM_REQ=4, IDX_W=2.
  - State enum {ST_IDLE, ST_GRANT}.
  - Function rr_pick(req, ptr) returning {found, idx}.
- Sub-module grant_dec_2x4: registered-input combinational 2-to-4 one-hot decode with an enable. Output is 0000 when enable=0; it drives gnt from gnt_idx and gnt_valid.
- Top holds the FSM, ptr, hold_cnt.

Test Plan:
1. Reset: drive rst_n=0 asynchronously mid-cycle with req=1111 -> gnt=0000, gnt_valid=0, gnt_idx=00 immediately; no grant while rst_n=0.
2. Single requester: req=0001, en=1 -> gnt=0001 after first edge. Hold req for 3 cycles, then drop -> gnt=0000 next edge. Second tenure to req=0001 goes to requester 0 again; ptr=01 does not starve it.
3. Timeout rotation, MAX_HOLD=4, req=1111 constant -> gnt sequence 0001 x4, 0000, 0010 x4, 0000, 0100 x4, 0000, 1000 x4, 0000, 0001 (wrap).
4. Priority search: after a tenure to idx 0 (ptr=01), req=1001 -> grant 1000 (idx 3). After release (ptr=00) -> grant 0001.
5. Enable gating: en=0, req=0110 for 5 cycles -> gnt=0000. Raise en -> gnt=0010 after next edge. Drop en during GRANT -> grant persists to timeout/release.
6. Reset mid-tenure: grant on idx 2, assert rst_n=0 -> gnt=0000 at once. Release reset with req=1111 -> first grant 0001 (ptr reset to 0).
